// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: IF/ID payload bundle and register control ops.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pcplus4;
    logic        valid;
  } ifid_t;

  typedef enum logic [1:0] {
    IFID_LOAD   = 2'd0,
    IFID_HOLD   = 2'd1,
    IFID_BUBBLE = 2'd2
  } ifid_op_t;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: loads a fetched payload, holds it, or replaces it with a bubble.
// One-cycle latency; a hold keeps the payload unchanged for as long as the stage is stalled.
module if_id_register
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic     clk,
  input  logic     rst,
  input  ifid_op_t op,
  input  ifid_t    load_dat,
  output ifid_t    payload
);

  ifid_t bubble;
  assign bubble = '{instruction: NOP_WORD, pcplus4: 32'd0, valid: 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      payload <= bubble;
    end else begin
      case (op)
        IFID_LOAD:   payload <= load_dat;
        IFID_BUBBLE: payload <= bubble;
        default:     payload <= payload;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// PC register, next-PC selection (redirect > stall/flush > sequential) and saturating fetch counter.
// Fetch latency 1 cycle; Stall freezes PC, IF/ID and the counter; no input reaches an output combinationally.
module instruction_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [31:0] IF_PC,
  input  logic [31:0] IF_Instruction,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectTarget,
  output logic [31:0] ID_Instruction,
  output logic [31:0] ID_PCPlus4,
  output logic        ID_Valid,
  output logic [31:0] FetchCount
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic [31:0] fetch_count;
  logic        count_en;
  ifid_op_t    ifid_op;
  ifid_t       load_dat;
  ifid_t       payload;

  assign pc_plus4 = pc + PC_INCR;
  assign load_dat = '{instruction: IF_Instruction, pcplus4: pc_plus4, valid: 1'b1};

  always_comb begin
    next_pc  = pc_plus4;
    ifid_op  = IFID_LOAD;
    count_en = 1'b0;
    if (RedirectValid) begin
      next_pc = {RedirectTarget[31:2], 2'b00};
      ifid_op = IFID_BUBBLE;
    end else if (Stall) begin
      next_pc = pc;
      ifid_op = Flush ? IFID_BUBBLE : IFID_HOLD;
    end else if (Flush) begin
      ifid_op = IFID_BUBBLE;
    end else begin
      count_en = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc          <= RESET_PC;
      fetch_count <= 32'd0;
    end else begin
      pc <= next_pc;
      // Saturate rather than wrap so a long-running counter never reads as small.
      if (count_en && (fetch_count != 32'hFFFF_FFFF)) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

  if_id_register #(
    .NOP_WORD (NOP_WORD)
  ) u_if_id (
    .clk      (Clk),
    .rst      (Reset),
    .op       (ifid_op),
    .load_dat (load_dat),
    .payload  (payload)
  );

  assign IF_PC          = pc;
  assign ID_Instruction = payload.instruction;
  assign ID_PCPlus4     = payload.pcplus4;
  assign ID_Valid       = payload.valid;
  assign FetchCount     = fetch_count;

endmodule
